// File: rtl/l1a_check_pkg.sv
// l1a_check_pkg: header marker layout and header detection shared by the L1A event checker.
package l1a_check_pkg;
  localparam logic [1:0] HDR_MARK = 2'b11;
  localparam int HDR_HI = 30;
  localparam int HDR_LO = 14;
  localparam int L1A_LSB = 0;
  function automatic logic is_header(input logic valid, input logic [31:0] w);
    return valid && w[HDR_HI +: 2] == HDR_MARK && w[HDR_LO +: 2] == HDR_MARK;
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: increment-by-one counter that sticks at all-ones, with sync clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) q <= '0;
    else if (clr) q <= '0;
    else if (inc && !(&q)) q <= q + 1'b1;
endmodule

// File: rtl/l1a_event_builder_check.sv
// l1a_event_builder_check: collects per-channel headers for the current L1A, declares
// completion or timeout, and keeps event/error statistics for readout validation.
module l1a_event_builder_check
  import l1a_check_pkg::*;
#(
  parameter int NUM_ADC   = 16,
  parameter int L1A_W     = 14,
  parameter int CNT_W     = 16,
  parameter int TIMEOUT   = 4096,
  parameter int FIRST_L1A = 1,
  localparam int CH_W     = $clog2(NUM_ADC)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               data_valid,
  input  logic [31:0]        data_in,
  input  logic [CH_W-1:0]    data_ch,
  output logic [CNT_W-1:0]   L1A_sent_counter,
  output logic [L1A_W-1:0]   current_L1A,
  output logic               event_done,
  output logic [CNT_W-1:0]   dup_err_count,
  output logic [CNT_W-1:0]   mismatch_count,
  output logic [CNT_W-1:0]   timeout_count,
  output logic [NUM_ADC-1:0] missing_mask
);
  localparam int TM_W = $clog2(TIMEOUT);
  logic [NUM_ADC-1:0] seen, onehot, seen_nx;
  logic [TM_W-1:0] timer;
  logic hdr, ch_ok, take, dup, mis, complete, expire, unused_bits;
  always_comb begin
    hdr = is_header(data_valid, data_in);
    // an out-of-range channel shifts the bit out entirely, which doubles as the range check
    onehot = NUM_ADC'(1) << data_ch;
    ch_ok = |onehot;
    take = hdr && ch_ok && data_in[L1A_LSB +: L1A_W] == current_L1A;
    seen_nx = take ? seen | onehot : seen;
    dup = take && |(seen & onehot);
    mis = hdr && !take;
    complete = &seen_nx;
    expire = |seen && timer == TM_W'(TIMEOUT - 1) && !complete;
    unused_bits = ^data_in;
  end
  sat_counter #(.W(CNT_W)) u_dup (.clk(clk), .reset_n(reset_n), .clr(clear), .inc(dup), .q(dup_err_count));
  sat_counter #(.W(CNT_W)) u_mis (.clk(clk), .reset_n(reset_n), .clr(clear), .inc(mis), .q(mismatch_count));
  sat_counter #(.W(CNT_W)) u_to (.clk(clk), .reset_n(reset_n), .clr(clear), .inc(expire), .q(timeout_count));
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      seen <= '0;
      timer <= '0;
      L1A_sent_counter <= '0;
      current_L1A <= L1A_W'(FIRST_L1A);
      event_done <= 1'b0;
      missing_mask <= '0;
    end else if (clear) begin
      seen <= '0;
      timer <= '0;
      L1A_sent_counter <= '0;
      current_L1A <= L1A_W'(FIRST_L1A);
      event_done <= 1'b0;
      missing_mask <= '0;
    end else begin
      event_done <= complete;
      seen <= (complete || expire) ? '0 : seen_nx;
      timer <= (complete || expire || !(|seen)) ? '0 : timer + 1'b1;
      if (complete) L1A_sent_counter <= L1A_sent_counter + 1'b1;
      if (complete || expire) current_L1A <= current_L1A + 1'b1;
      if (expire) missing_mask <= ~seen;
    end
endmodule

// File: tb/tb_l1a_event_builder_check.sv
// tb_l1a_event_builder_check: directed scenarios plus random traffic against a cycle-indexed event model.
module tb_l1a_event_builder_check;
  localparam int TO = 4096;
  logic clk = 0, reset_n = 0, clear = 0, data_valid = 0;
  logic [31:0] data_in = '0;
  logic [3:0] data_ch = '0;
  logic [15:0] sent, dupc, misc, toc, mask;
  logic [13:0] cur;
  logic done;
  logic [15:0] w_sent, w_dup, w_mis, w_to, w_mask;
  logic [13:0] w_cur;
  logic w_done;
  int total = 0, bad = 0;
  int m_cur, m_sent, m_dup, m_mis, m_to;
  longint m_first, n = 0;
  bit [15:0] m_mask;
  bit m_done;
  bit m_got[16];

  always #5 clk = ~clk;

  l1a_event_builder_check dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .data_valid(data_valid),
    .data_in(data_in), .data_ch(data_ch), .L1A_sent_counter(sent), .current_L1A(cur),
    .event_done(done), .dup_err_count(dupc), .mismatch_count(misc),
    .timeout_count(toc), .missing_mask(mask)
  );

  l1a_event_builder_check #(.TIMEOUT(16), .FIRST_L1A(14'h3FFF)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .clear(clear), .data_valid(data_valid),
    .data_in(data_in), .data_ch(data_ch), .L1A_sent_counter(w_sent), .current_L1A(w_cur),
    .event_done(w_done), .dup_err_count(w_dup), .mismatch_count(w_mis),
    .timeout_count(w_to), .missing_mask(w_mask)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("sent", 32'(sent), 32'(m_sent));
    chk("cur", 32'(cur), 32'(m_cur));
    chk("done", 32'(done), 32'(m_done));
    chk("dup", 32'(dupc), 32'(m_dup));
    chk("mis", 32'(misc), 32'(m_mis));
    chk("timeout", 32'(toc), 32'(m_to));
    chk("mask", 32'(mask), 32'(m_mask));
  endtask

  task automatic mreset();
    m_cur = 1; m_sent = 0; m_dup = 0; m_mis = 0; m_to = 0;
    m_mask = '0; m_done = 0; m_first = -1;
    foreach (m_got[i]) m_got[i] = 0;
  endtask

  function automatic int sat(input int v);
    return v >= 65535 ? 65535 : v + 1;
  endfunction

  // event-level model: an L1A opens at its first accepted header and expires TO cycles later
  task automatic mstep(input bit clr, input bit v, input logic [31:0] w, input int ch);
    bit hdr, acc;
    int have;
    if (clr) begin
      mreset();
      return;
    end
    hdr = v && w[31:30] == 2'b11 && w[15:14] == 2'b11;
    acc = hdr && ch < 16 && int'(w[13:0]) == m_cur;
    if (hdr && !acc) m_mis = sat(m_mis);
    if (acc && m_got[ch]) m_dup = sat(m_dup);
    have = 0;
    for (int i = 0; i < 16; i++) have += (m_got[i] || (acc && ch == i)) ? 1 : 0;
    m_done = have == 16;
    if (m_done) begin
      m_sent = (m_sent + 1) % 65536;
      m_cur = (m_cur + 1) % 16384;
      foreach (m_got[i]) m_got[i] = 0;
      m_first = -1;
    end else if (m_first >= 0 && n - m_first == TO) begin
      m_to = sat(m_to);
      for (int i = 0; i < 16; i++) m_mask[i] = !m_got[i];
      m_cur = (m_cur + 1) % 16384;
      foreach (m_got[i]) m_got[i] = 0;
      m_first = -1;
    end else if (acc) begin
      if (m_first < 0) m_first = n;
      m_got[ch] = 1;
    end
  endtask

  task automatic cyc(input bit clr, input bit v, input logic [31:0] w, input int ch);
    clear = clr; data_valid = v; data_in = w; data_ch = 4'(ch);
    mstep(clr, v, w, ch);
    @(posedge clk); #1;
    n++;
    check_all();
  endtask

  function automatic logic [31:0] hw(input int l);
    return {2'b11, 14'h0, 2'b11, l[13:0]};
  endfunction

  task automatic idle();
    cyc(0, 0, 32'h0, 0);
  endtask

  initial begin
    longint n0;
    int l1a, ch;
    bit clr, v;
    logic [31:0] w;
    mreset();
    repeat (2) @(posedge clk);
    #1 check_all();
    @(negedge clk) reset_n = 1;
    @(posedge clk); #1; n++;

    // full event on L1A=1
    for (int c = 0; c < 16; c++) cyc(0, 1, hw(1), c);
    chk("t1_done", 32'(done), 1);
    chk("t1_sent", 32'(sent), 1);
    chk("t1_cur", 32'(cur), 2);
    idle();
    chk("t1_done_pulse", 32'(done), 0);

    // duplicate header from ch3
    cyc(1, 0, 32'h0, 0);
    cyc(0, 1, hw(1), 3);
    cyc(0, 1, hw(1), 3);
    for (int c = 0; c < 16; c++) if (c != 3) cyc(0, 1, hw(1), c);
    chk("t2_dup", 32'(dupc), 1);
    chk("t2_sent", 32'(sent), 1);

    // wrong L1A is counted and ignored
    cyc(1, 0, 32'h0, 0);
    cyc(0, 1, hw(1), 0);
    cyc(0, 1, hw(5), 1);
    chk("t3_mis", 32'(misc), 1);
    chk("t3_cur", 32'(cur), 1);
    cyc(0, 1, 32'h1234_0001, 2);
    chk("t3_nonhdr", 32'(misc), 1);

    // ch15 never arrives
    cyc(1, 0, 32'h0, 0);
    for (int c = 0; c < 15; c++) cyc(0, 1, hw(1), c);
    repeat (TO) idle();
    chk("t4_to", 32'(toc), 1);
    chk("t4_mask", 32'(mask), 32'h8000);
    chk("t4_cur", 32'(cur), 2);
    chk("t4_sent", 32'(sent), 0);

    // last header lands exactly on the final allowed cycle
    cyc(1, 0, 32'h0, 0);
    n0 = n;
    for (int c = 0; c < 15; c++) cyc(0, 1, hw(1), c);
    while (n < n0 + TO) idle();
    cyc(0, 1, hw(1), 15);
    chk("t6_done", 32'(done), 1);
    chk("t6_sent", 32'(sent), 1);
    chk("t6_to", 32'(toc), 0);
    repeat (3) idle();

    // L1A field wraps, then async reset mid-event
    cyc(1, 0, 32'h0, 0);
    for (int c = 0; c < 16; c++) cyc(0, 1, hw(14'h3FFF), c);
    chk("t5_wdone", 32'(w_done), 1);
    chk("t5_wcur", 32'(w_cur), 0);
    chk("t5_wsent", 32'(w_sent), 1);
    for (int c = 0; c < 5; c++) cyc(0, 1, hw(0), c);
    data_valid = 0; clear = 0;
    #2 reset_n = 0;
    #1;
    mreset();
    check_all();
    chk("t5_wcur_rst", 32'(w_cur), 32'h3FFF);
    chk("t5_wsent_rst", 32'(w_sent), 0);
    chk("t5_wdone_rst", 32'(w_done), 0);
    @(negedge clk) reset_n = 1;
    @(posedge clk); #1; n++;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      clr = $urandom_range(399) == 0;
      v = $urandom_range(99) < 85;
      ch = int'($urandom_range(15));
      l1a = $urandom_range(3) != 0 ? m_cur : int'($urandom_range(16383));
      w = $urandom_range(9) < 7 ? hw(l1a) : ($urandom & 32'h7FFF_FFFF);
      cyc(clr, v, w, ch);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
